// File: rtl/alu_mc_if.sv
// Command/result handshake bundle for the multi-cycle ALU.
interface alu_mc_if #(
   parameter int N    = 8,
   parameter int OP_W = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] op;
   logic [N-1:0]    data_a;
   logic [N-1:0]    data_b;
   logic            carry_in;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    S;
   logic [N-1:0]    S_hi;
   logic            zero;
   logic            negative;
   logic            carry_out;
   logic            overflow;
   logic            err;

   modport master (
      output in_valid, op, data_a, data_b, carry_in, out_ready,
      input  in_ready, out_valid, S, S_hi, zero, negative, carry_out, overflow, err
   );

   modport slave (
      input  in_valid, op, data_a, data_b, carry_in, out_ready,
      output in_ready, out_valid, S, S_hi, zero, negative, carry_out, overflow, err
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts,
// shift-add multiply and restoring divide, behind a valid/ready handshake.
module alu_mc #(
   parameter int N    = 8,
   parameter int OP_W = 4
) (
   input logic   clk,
   input logic   rst_n,
   alu_mc_if.slave bus
);
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [OP_W-1:0] OP_AD   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SB   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADX  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SBX  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AN   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_XR   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_LS   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SHL  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SHR  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nx;
   logic [OP_W-1:0] op_q;
   logic [CNT_W-1:0] cnt, amt, ld_cnt;
   logic [N-1:0]    w_hi, w_lo, w_m, ld_lo, ld_m;
   logic            w_c;
   logic [N:0]      sum, mul_sum, div_sh;
   logic [N-1:0]    r_s, r_hi, st_hi, st_lo, f_hi, o_s, o_hi;
   logic            r_c, r_v, r_err, multi, st_c, f_c, o_c, o_v, o_err;
   logic            accept, last, o_load;
   logic [N-1:0]    s_q, s_hi_q;
   logic            zero_q, neg_q, c_q, v_q, err_q;

   assign accept = bus.in_valid && (state == IDLE);
   assign last   = (state == CALC) && (cnt == CNT_W'(1));
   assign amt    = CNT_W'(bus.data_b % N);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = multi ? CALC : DONE;
         CALC:    if (cnt == CNT_W'(1)) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle results straight from the inputs, plus the work-register
   // preload for ops that must iterate.
   always_comb begin
      sum    = '0;
      r_s    = '0;
      r_hi   = '0;
      r_c    = 1'b0;
      r_v    = 1'b0;
      r_err  = 1'b0;
      multi  = 1'b0;
      ld_lo  = '0;
      ld_m   = '0;
      ld_cnt = '0;
      case (bus.op)
         OP_AD, OP_ADX: begin
            sum = {1'b0, bus.data_a} + {1'b0, bus.data_b}
                + {{N{1'b0}}, (bus.op == OP_AD) & bus.carry_in};
            r_s = sum[N-1:0];
            r_c = sum[N];
            r_v = (bus.data_a[N-1] == bus.data_b[N-1]) && (sum[N-1] != bus.data_a[N-1]);
         end
         OP_SB, OP_SBX: begin
            if (bus.op == OP_SB) begin
               sum = {1'b0, bus.data_a} + {1'b0, ~bus.data_b} + {{N{1'b0}}, bus.carry_in};
               r_c = ~sum[N];
            end else begin
               sum = {1'b0, bus.data_a} - {1'b0, bus.data_b};
               r_c = sum[N];
            end
            r_s = sum[N-1:0];
            r_v = (bus.data_a[N-1] != bus.data_b[N-1]) && (sum[N-1] != bus.data_a[N-1]);
         end
         OP_AN: r_s = bus.data_a & bus.data_b;
         OP_OR: r_s = bus.data_a | bus.data_b;
         OP_XR: r_s = bus.data_a ^ bus.data_b;
         OP_LS: r_s = {{(N-1){1'b0}}, bus.data_a < bus.data_b};
         OP_SHL, OP_SHR: begin
            if (amt == '0) begin
               r_s = bus.data_a;
            end else begin
               multi  = 1'b1;
               ld_lo  = bus.data_a;
               ld_cnt = amt;
            end
         end
         OP_MUL: begin
            multi  = 1'b1;
            ld_lo  = bus.data_b;
            ld_m   = bus.data_a;
            ld_cnt = CNT_W'(N);
         end
         OP_DIVU: begin
            if (bus.data_b == '0) begin
               r_s   = '1;
               r_hi  = bus.data_a;
               r_err = 1'b1;
            end else begin
               multi  = 1'b1;
               ld_lo  = bus.data_a;
               ld_m   = bus.data_b;
               ld_cnt = CNT_W'(N);
            end
         end
         default: r_err = 1'b1;
      endcase
   end

   // One iteration: w_hi/w_lo hold the product halves for MUL and the
   // remainder/quotient for DIVU; w_lo alone is the shift register.
   always_comb begin
      st_hi   = w_hi;
      st_lo   = w_lo;
      st_c    = w_c;
      mul_sum = '0;
      div_sh  = '0;
      f_hi    = '0;
      f_c     = 1'b0;
      case (op_q)
         OP_SHL: begin
            st_c  = w_lo[N-1];
            st_lo = {w_lo[N-2:0], 1'b0};
            f_c   = st_c;
         end
         OP_SHR: begin
            st_c  = w_lo[0];
            st_lo = {1'b0, w_lo[N-1:1]};
            f_c   = st_c;
         end
         OP_MUL: begin
            mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_m} : '0);
            st_hi   = mul_sum[N:1];
            st_lo   = {mul_sum[0], w_lo[N-1:1]};
            f_hi    = st_hi;
            f_c     = |st_hi;
         end
         OP_DIVU: begin
            div_sh = {w_hi, w_lo[N-1]};
            if (div_sh >= {1'b0, w_m}) begin
               st_hi = div_sh[N-1:0] - w_m;
               st_lo = {w_lo[N-2:0], 1'b1};
            end else begin
               st_hi = div_sh[N-1:0];
               st_lo = {w_lo[N-2:0], 1'b0};
            end
            f_hi = st_hi;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_load = (accept && !multi) || last;
      o_s    = last ? st_lo : r_s;
      o_hi   = last ? f_hi  : r_hi;
      o_c    = last ? f_c   : r_c;
      o_v    = last ? 1'b0  : r_v;
      o_err  = last ? 1'b0  : r_err;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q   <= '0;
         cnt    <= '0;
         w_hi   <= '0;
         w_lo   <= '0;
         w_m    <= '0;
         w_c    <= 1'b0;
         s_q    <= '0;
         s_hi_q <= '0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         c_q    <= 1'b0;
         v_q    <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= bus.op;
            cnt  <= ld_cnt;
            w_hi <= '0;
            w_lo <= ld_lo;
            w_m  <= ld_m;
            w_c  <= 1'b0;
         end else if (state == CALC) begin
            cnt  <= cnt - CNT_W'(1);
            w_hi <= st_hi;
            w_lo <= st_lo;
            w_c  <= st_c;
         end
         if (o_load) begin
            s_q    <= o_s;
            s_hi_q <= o_hi;
            zero_q <= ~|o_s;
            neg_q  <= o_s[N-1];
            c_q    <= o_c;
            v_q    <= o_v;
            err_q  <= o_err;
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.S         = s_q;
   assign bus.S_hi      = s_hi_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = neg_q;
   assign bus.carry_out = c_q;
   assign bus.overflow  = v_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (N=8) with hand-computed expectations.
module tb_alu_mc;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passCount = 0;
   int   checkCount = 0;
   int   latency;
   logic readyLow;

   alu_mc_if #(.N(N), .OP_W(4)) bus ();

   alu_mc #(.N(N), .OP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   // Issues one command, scrambles the inputs after accept, then waits
   // (bounded) for out_valid while noting whether in_ready ever rose.
   task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic cin);
      @(posedge clk); #1;
      bus.op       = op;
      bus.data_a   = a;
      bus.data_b   = b;
      bus.carry_in = cin;
      bus.in_valid = 1'b1;
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op       = 4'hF;
      bus.data_a   = ~a;
      bus.data_b   = ~b;
      bus.carry_in = ~cin;
      latency  = 1;
      readyLow = 1'b1;
      while (!bus.out_valid && latency < 100) begin
         if (bus.in_ready) readyLow = 1'b0;
         @(posedge clk); #1;
         latency++;
      end
      if (!bus.out_valid) checkOutput({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic checkResult(input string tag, input int expLat, input logic [7:0] expS,
                              input logic [7:0] expHi, input logic [4:0] expFlags);
      checkOutput({tag, "_latency"}, 32'(latency), 32'(expLat));
      checkOutput({tag, "_S"}, 32'(bus.S), 32'(expS));
      checkOutput({tag, "_S_hi"}, 32'(bus.S_hi), 32'(expHi));
      checkOutput({tag, "_flags"},
                  32'({bus.zero, bus.negative, bus.carry_out, bus.overflow, bus.err}),
                  32'(expFlags));
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   // Flags are packed {zero, negative, carry_out, overflow, err}.
   initial begin
      bus.in_valid  = 1'b1;
      bus.op        = 4'd0;
      bus.data_a    = 8'h11;
      bus.data_b    = 8'h22;
      bus.carry_in  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_S", 32'(bus.S), 32'd0);
      checkOutput("reset_flags", 32'({bus.zero, bus.negative, bus.carry_out, bus.overflow, bus.err}), 32'd0);

      applyStimulus("ad_ff_01", 4'd0, 8'hFF, 8'h01, 1'b0);
      checkResult("ad_ff_01", 1, 8'h00, 8'h00, 5'b10100);
      consume("ad_ff_01");

      applyStimulus("ad_cin", 4'd0, 8'h7F, 8'h00, 1'b1);
      checkResult("ad_cin", 1, 8'h80, 8'h00, 5'b01010);
      consume("ad_cin");

      applyStimulus("sb", 4'd1, 8'h10, 8'h20, 1'b1);
      checkResult("sb", 1, 8'hF0, 8'h00, 5'b01100);
      consume("sb");

      applyStimulus("sbx", 4'd3, 8'h80, 8'h01, 1'b0);
      checkResult("sbx", 1, 8'h7F, 8'h00, 5'b00010);
      consume("sbx");

      applyStimulus("adx", 4'd2, 8'h7F, 8'h01, 1'b1);
      checkResult("adx", 1, 8'h80, 8'h00, 5'b01010);
      consume("adx");

      applyStimulus("an", 4'd4, 8'hF0, 8'h3C, 1'b0);
      checkResult("an", 1, 8'h30, 8'h00, 5'b00000);
      consume("an");

      applyStimulus("or", 4'd5, 8'h0F, 8'h30, 1'b0);
      checkResult("or", 1, 8'h3F, 8'h00, 5'b00000);
      consume("or");

      applyStimulus("xr", 4'd6, 8'hF0, 8'h3C, 1'b0);
      checkResult("xr", 1, 8'hCC, 8'h00, 5'b01000);
      consume("xr");

      applyStimulus("ls_lt", 4'd7, 8'h03, 8'h05, 1'b0);
      checkResult("ls_lt", 1, 8'h01, 8'h00, 5'b00000);
      consume("ls_lt");

      applyStimulus("ls_ge", 4'd7, 8'h05, 8'h03, 1'b0);
      checkResult("ls_ge", 1, 8'h00, 8'h00, 5'b10000);
      consume("ls_ge");

      applyStimulus("mul_ff", 4'd10, 8'hFF, 8'hFF, 1'b0);
      checkResult("mul_ff", 9, 8'h01, 8'hFE, 5'b00100);
      checkOutput("mul_ff_busy", 32'(readyLow), 32'd1);
      consume("mul_ff");

      applyStimulus("mul_small", 4'd10, 8'h03, 8'h05, 1'b0);
      checkResult("mul_small", 9, 8'h0F, 8'h00, 5'b00000);
      consume("mul_small");

      applyStimulus("divu", 4'd11, 8'h64, 8'h07, 1'b0);
      checkResult("divu", 9, 8'h0E, 8'h02, 5'b00000);
      consume("divu");

      applyStimulus("divu_zero", 4'd11, 8'h5A, 8'h00, 1'b0);
      checkResult("divu_zero", 1, 8'hFF, 8'h5A, 5'b01001);
      consume("divu_zero");

      applyStimulus("illegal", 4'd13, 8'h12, 8'h34, 1'b1);
      checkResult("illegal", 1, 8'h00, 8'h00, 5'b10001);
      consume("illegal");

      applyStimulus("shr3", 4'd9, 8'h85, 8'h03, 1'b0);
      checkResult("shr3", 4, 8'h10, 8'h00, 5'b00100);
      consume("shr3");

      applyStimulus("shl_amt0", 4'd8, 8'h5A, 8'h08, 1'b0);
      checkResult("shl_amt0", 1, 8'h5A, 8'h00, 5'b00000);
      consume("shl_amt0");

      applyStimulus("shl_hold", 4'd8, 8'h81, 8'h09, 1'b0);
      checkResult("shl_hold", 2, 8'h02, 8'h00, 5'b00100);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("hold_S", 32'(bus.S), 32'h02);
         checkOutput("hold_carry", 32'(bus.carry_out), 32'd1);
      end
      consume("shl_hold");

      // Abort a multiply four cycles in; in_valid is held high during the
      // reset cycle to show it is ignored.
      @(posedge clk); #1;
      bus.op       = 4'd10;
      bus.data_a   = 8'h0F;
      bus.data_b   = 8'h0F;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_busy", 32'(bus.in_ready), 32'd0);
      rst_n        = 1'b0;
      bus.op       = 4'd0;
      bus.data_a   = 8'h01;
      bus.data_b   = 8'h01;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("abort_S", 32'(bus.S), 32'd0);
      checkOutput("abort_S_hi", 32'(bus.S_hi), 32'd0);
      checkOutput("abort_flags", 32'({bus.zero, bus.negative, bus.carry_out, bus.overflow, bus.err}), 32'd0);
      readyLow = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) readyLow = 1'b1;
      end
      checkOutput("abort_never_valid", 32'(readyLow), 32'd0);

      applyStimulus("ad_after_abort", 4'd0, 8'h12, 8'h34, 1'b1);
      checkResult("ad_after_abort", 1, 8'h47, 8'h00, 5'b00000);
      consume("ad_after_abort");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
